// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: holds PLL reset, waits for a debounced lock with
// timeout/retry, staggers the clock-buffer enables, then releases sys_rst.
// Any loss of lock after outputs start enabling restarts the whole sequence.
//
//  state     | meaning
//  HOLD      | pll_rst asserted for RST_HOLD cycles
//  WAIT_LOCK | pll_rst released, waiting for synced lock (with timeout)
//  STABLE    | counting consecutive synced-lock cycles
//  ENABLE    | turning on clkout_ce bits one every CE_STAGGER cycles
//  RUN       | all outputs enabled, sys_rst released, ready high
//  FAIL      | retries exhausted, parked until start
module pll_reset_sequencer #(
  parameter int NUM_CLKOUT   = 3,
  parameter int RST_HOLD     = 16,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int LOCK_STABLE  = 64,
  parameter int CE_STAGGER   = 8,
  parameter int MAX_RETRIES  = 3,
  localparam int RW          = $clog2(MAX_RETRIES + 1)
) (
  input  logic                  clk,
  input  logic                  cpu_reset_n,
  input  logic                  start,
  input  logic                  pll_locked,
  output logic                  pll_rst,
  output logic [NUM_CLKOUT-1:0] clkout_ce,
  output logic                  sys_rst,
  output logic                  ready,
  output logic                  fail,
  output logic [RW-1:0]         retry_cnt
);

  localparam int M1   = (RST_HOLD > LOCK_TIMEOUT) ? RST_HOLD : LOCK_TIMEOUT;
  localparam int M2   = (LOCK_STABLE > CE_STAGGER) ? LOCK_STABLE : CE_STAGGER;
  localparam int CMAX = (M1 > M2) ? M1 : M2;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int IW   = (NUM_CLKOUT > 1) ? $clog2(NUM_CLKOUT) : 1;

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    ENABLE    = 3'd3,
    RUN       = 3'd4,
    FAIL      = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [RW-1:0]         retry_d;
  logic [NUM_CLKOUT-1:0] ce_d;
  logic                  sync1, lock_s;

  // Two-flop synchroniser for the asynchronous PLL LOCKED signal.
  always_ff @(posedge clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= pll_locked;
      lock_s <= sync1;
    end
  end

  // State, counters and registered outputs; outputs follow the next state.
  always_ff @(posedge clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      state_q   <= HOLD;
      cnt_q     <= '0;
      idx_q     <= '0;
      retry_cnt <= '0;
      clkout_ce <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      retry_cnt <= retry_d;
      clkout_ce <= ce_d;
      pll_rst   <= (state_d == HOLD) || (state_d == FAIL);
      sys_rst   <= (state_d != RUN);
      ready     <= (state_d == RUN);
      fail      <= (state_d == FAIL);
    end
  end

  // Next-state logic; start overrides everything, lock loss after STABLE restarts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    retry_d = retry_cnt;
    ce_d    = clkout_ce;
    if (start) begin
      state_d = HOLD;
      cnt_d   = '0;
      retry_d = '0;
      ce_d    = '0;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == CW'(RST_HOLD - 1)) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
            cnt_d = '0;
            if (retry_cnt == RW'(MAX_RETRIES)) begin
              state_d = FAIL;
            end else begin
              state_d = HOLD;
              retry_d = retry_cnt + RW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == CW'(LOCK_STABLE - 1)) begin
            state_d = ENABLE;
            cnt_d   = '0;
            idx_d   = '0;
            ce_d    = NUM_CLKOUT'(1);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ENABLE: begin
          if (!lock_s) begin
            state_d = HOLD;
            cnt_d   = '0;
            retry_d = '0;
            ce_d    = '0;
          end else if (cnt_q == CW'(CE_STAGGER - 1)) begin
            cnt_d = '0;
            if (idx_q == IW'(NUM_CLKOUT - 1)) begin
              state_d = RUN;
            end else begin
              idx_d = idx_q + IW'(1);
              ce_d  = clkout_ce | (NUM_CLKOUT'(1) << (idx_q + IW'(1)));
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_d = HOLD;
            cnt_d   = '0;
            retry_d = '0;
            ce_d    = '0;
          end
        end
        FAIL: begin
          ce_d = '0;
        end
        default: begin
          state_d = HOLD;
          cnt_d   = '0;
          ce_d    = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with default parameters.
// Cycle k means the negedge following the k-th posedge after reset release.
module tb_pll_reset_sequencer;
   logic       clk = 1'b0;
   logic       cpu_reset_n = 1'b0;
   logic       start = 1'b0;
   logic       pll_locked = 1'b0;
   logic       pll_rst;
   logic [2:0] clkout_ce;
   logic       sys_rst;
   logic       ready;
   logic       fail;
   logic [1:0] retry_cnt;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   pll_reset_sequencer dut (
      .clk(clk), .cpu_reset_n(cpu_reset_n), .start(start), .pll_locked(pll_locked),
      .pll_rst(pll_rst), .clkout_ce(clkout_ce), .sys_rst(sys_rst), .ready(ready),
      .fail(fail), .retry_cnt(retry_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic to(input int k);
      while (cyc < k) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      cpu_reset_n = 1'b0;
      repeat (3) @(negedge clk);
      cpu_reset_n = 1'b1;
      cyc = 0;
   endtask

   initial begin
      // 1: defaults, lock arrives 50 cycles after release
      repeat (2) @(negedge clk);
      chk("rst_pll_rst", pll_rst, 1'b1);
      chk("rst_ce", clkout_ce, 3'b000);
      chk("rst_sys_rst", sys_rst, 1'b1);
      chk("rst_ready", ready, 1'b0);
      chk("rst_fail", fail, 1'b0);
      chk("rst_retry", retry_cnt, 2'd0);
      do_reset();
      to(15);  chk("t1_pll_rst_15", pll_rst, 1'b1);
      to(16);  chk("t1_pll_rst_16", pll_rst, 1'b0);
      to(50);  pll_locked = 1'b1;
      to(116); chk("t1_ce_116", clkout_ce, 3'b000);
      to(117); chk("t1_ce_117", clkout_ce, 3'b001);
      to(124); chk("t1_ce_124", clkout_ce, 3'b001);
      to(125); chk("t1_ce_125", clkout_ce, 3'b011);
      to(132); chk("t1_ce_132", clkout_ce, 3'b011);
      to(133); chk("t1_ce_133", clkout_ce, 3'b111);
      to(140); chk("t1_sys_rst_140", sys_rst, 1'b1);
               chk("t1_ready_140", ready, 1'b0);
      to(141); chk("t1_sys_rst_141", sys_rst, 1'b0);
               chk("t1_ready_141", ready, 1'b1);
               chk("t1_pll_rst_141", pll_rst, 1'b0);

      // 4: lock loss in RUN, then re-lock
      to(150); pll_locked = 1'b0;
      to(152); chk("t4_ce_152", clkout_ce, 3'b111);
               chk("t4_ready_152", ready, 1'b1);
      to(153); chk("t4_ce_153", clkout_ce, 3'b000);
               chk("t4_sys_rst_153", sys_rst, 1'b1);
               chk("t4_ready_153", ready, 1'b0);
               chk("t4_pll_rst_153", pll_rst, 1'b1);
               chk("t4_retry_153", retry_cnt, 2'd0);
      to(160); pll_locked = 1'b1;
      to(168); chk("t4_pll_rst_168", pll_rst, 1'b1);
      to(169); chk("t4_pll_rst_169", pll_rst, 1'b0);
      to(233); chk("t4_ce_233", clkout_ce, 3'b000);
      to(234); chk("t4_ce_234", clkout_ce, 3'b001);
      to(257); chk("t4_ready_257", ready, 1'b0);
      to(258); chk("t4_ready_258", ready, 1'b1);
               chk("t4_ce_258", clkout_ce, 3'b111);

      // 2: one-cycle lock glitch at stable count 40
      pll_locked = 1'b0;
      do_reset();
      to(50);  pll_locked = 1'b1;
      to(93);  pll_locked = 1'b0;
      to(94);  pll_locked = 1'b1;
      to(120); chk("t2_ce_120", clkout_ce, 3'b000);
               chk("t2_pll_rst_120", pll_rst, 1'b0);
      to(160); chk("t2_ce_160", clkout_ce, 3'b000);
      to(161); chk("t2_ce_161", clkout_ce, 3'b001);
               chk("t2_retry_161", retry_cnt, 2'd0);

      // 3: lock never arrives -> retries then FAIL, start clears
      pll_locked = 1'b0;
      do_reset();
      to(1039); chk("t3_pll_rst_1039", pll_rst, 1'b0);
                chk("t3_retry_1039", retry_cnt, 2'd0);
      to(1040); chk("t3_pll_rst_1040", pll_rst, 1'b1);
                chk("t3_retry_1040", retry_cnt, 2'd1);
      to(1056); chk("t3_pll_rst_1056", pll_rst, 1'b0);
      to(2080); chk("t3_retry_2080", retry_cnt, 2'd2);
      to(3120); chk("t3_retry_3120", retry_cnt, 2'd3);
      to(4159); chk("t3_fail_4159", fail, 1'b0);
                chk("t3_pll_rst_4159", pll_rst, 1'b0);
      to(4160); chk("t3_fail_4160", fail, 1'b1);
                chk("t3_pll_rst_4160", pll_rst, 1'b1);
                chk("t3_sys_rst_4160", sys_rst, 1'b1);
                chk("t3_retry_4160", retry_cnt, 2'd3);
      to(4200); chk("t3_fail_sticky", fail, 1'b1);
                chk("t3_ready_fail", ready, 1'b0);
      start = 1'b1;
      to(4201); start = 1'b0;
                chk("t3_fail_start", fail, 1'b0);
                chk("t3_retry_start", retry_cnt, 2'd0);
                chk("t3_pll_rst_start", pll_rst, 1'b1);

      // 5: start and lock loss together during ENABLE with ce=011
      do_reset();
      to(50);  pll_locked = 1'b1;
      to(125); pll_locked = 1'b0;
      to(127); chk("t5_ce_127", clkout_ce, 3'b011);
               start = 1'b1;
      to(128); start = 1'b0;
               chk("t5_ce_128", clkout_ce, 3'b000);
               chk("t5_pll_rst_128", pll_rst, 1'b1);
               chk("t5_sys_rst_128", sys_rst, 1'b1);
               chk("t5_retry_128", retry_cnt, 2'd0);
      to(143); chk("t5_pll_rst_143", pll_rst, 1'b1);
      to(144); chk("t5_pll_rst_144", pll_rst, 1'b0);

      // 6: asynchronous reset mid-ENABLE
      do_reset();
      to(50);  pll_locked = 1'b1;
      to(126); chk("t6_ce_126", clkout_ce, 3'b011);
      #2 cpu_reset_n = 1'b0;
      #1;
      chk("t6_async_pll_rst", pll_rst, 1'b1);
      chk("t6_async_ce", clkout_ce, 3'b000);
      chk("t6_async_sys_rst", sys_rst, 1'b1);
      chk("t6_async_ready", ready, 1'b0);
      chk("t6_async_fail", fail, 1'b0);
      chk("t6_async_retry", retry_cnt, 2'd0);
      @(negedge clk);
      cpu_reset_n = 1'b1;
      cyc = 0;
      to(15);  chk("t6_pll_rst_15", pll_rst, 1'b1);
      to(16);  chk("t6_pll_rst_16", pll_rst, 1'b0);
      to(80);  chk("t6_ce_80", clkout_ce, 3'b000);
      to(81);  chk("t6_ce_81", clkout_ce, 3'b001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
